// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants, bit order and slave FSM states
package spi_pkg;

  localparam int SPI_FRAME_W = 12;
  localparam bit LSB_FIRST   = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    WAIT_CS = 2'd2
  } spi_state_e;

  // Maps the running bit count onto a word bit position for the chosen bit order.
  function automatic int bit_index(input int count, input int width);
    return LSB_FIRST ? count : width - 1 - count;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall detection on the synchronised level
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = ~prev_q & level_o;
  assign fall_o  = prev_q & ~level_o;

endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - oversampled SPI slave: captures a frame on mosi and answers on miso
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_FRAME_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(sclk), .level_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(cs), .level_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi), .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sync = sclk_s ^ cs_s ^ mosi_rise ^ mosi_fall;

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              miso_q, miso_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;
  logic              load;

  assign load = tx_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    miso_d      = miso_q;
    rx_done_d   = 1'b0;
    rx_valid_d  = rx_done_q;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    if (load) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        miso_d  = 1'b0;
        count_d = '0;
        if (cs_fall) begin
          state_d     = ACTIVE;
          rx_shift_d  = '0;
          hold_full_d = 1'b0;
          // A word loaded in the same cycle as the frame start goes straight out.
          if (hold_full_q) begin
            tx_shift_d = hold_q;
          end else if (load) begin
            tx_shift_d = tx_data;
          end else begin
            tx_shift_d = '0;
            underrun_d = 1'b1;
          end
        end
      end

      ACTIVE: begin
        if (sclk_fall) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (bit_index(int'(count_q), DATA_W) == i) rx_shift_d[i] = mosi_s;
          end
          count_d = count_q + CNT_W'(1);
        end
        // Completion wins over a coincident cs rise; that rise also ends the frame.
        if (sclk_fall && count_q == LAST_BIT) begin
          rx_data_d = rx_shift_d;
          rx_done_d = 1'b1;
          if (cs_rise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            count_d = '0;
          end else begin
            state_d = WAIT_CS;
          end
        end else if (cs_rise) begin
          state_d     = IDLE;
          miso_d      = 1'b0;
          count_d     = '0;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          miso_d     = LSB_FIRST ? tx_shift_q[0] : tx_shift_q[DATA_W-1];
          tx_shift_d = LSB_FIRST ? (tx_shift_q >> 1) : (tx_shift_q << 1);
        end
      end

      WAIT_CS: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          count_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      rx_done_q   <= rx_done_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;

endmodule
